my_computer_sys: RTL and testbench

- Parametrised next-generation Hack system top.
- Wraps my_cpu with on-chip instruction RAM, data RAM and one memory-mapped I/O port.
- Instruction RAM is loaded over a valid/ready stream rather than fixed ROM.
- Adds a run-control FSM (LOAD/RUN/HALT), hardware halt detection and a cycle counter; sits at top level under the bench or board wrapper.

---
 rtl/my_computer_sys.sv | 180 ++++++++++++++++++
 tb/tb_my_computer_sys.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/my_computer_sys.sv
module my_computer_sys #(
  parameter int unsigned IMEM_AW     = 15,
  parameter int unsigned DMEM_AW     = 14,
  parameter logic [15:0] IO_ADDR     = 16'h6000,
  parameter int unsigned CYC_W       = 32,
  parameter int unsigned WDOG_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [15:0]        load_data,
  input  logic               load_last,
  input  logic [15:0]        io_in,
  output logic [15:0]        io_out,
  output logic               io_out_valid,
  output logic               running,
  output logic               halted,
  output logic [CYC_W-1:0]   cycles,
  output logic [IMEM_AW-1:0] pc
`ifdef MY_COMPUTER_SYS_WDOG_EN
  ,
  output logic               wdog_fired
`endif
);

  localparam int unsigned IMEM_DEPTH = 2**IMEM_AW;
  localparam int unsigned DMEM_DEPTH = 2**DMEM_AW;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;
  state_t state, state_next;

  logic [15:0]        imem [IMEM_DEPTH];
  logic [15:0]        dmem [DMEM_DEPTH];

  logic [IMEM_AW-1:0] load_ptr;
  logic               load_fire;
  logic [15:0]        instr;
  logic [15:0]        a_reg, d_reg;
  logic               cpu_go;
  logic               is_c;
  logic [15:0]        y_op, x_v, y_v, alu;
  logic               zr, ng, take_jump, write_m;
  logic               dmem_hit, io_hit;
  logic [15:0]        in_m;
  logic [IMEM_AW-1:0] prev_pc;
  logic               prev_at;
  logic               halt_hit;
  logic               wdog_hit;

  assign load_fire = (state == S_LOAD) && load_valid;
  assign instr     = imem[pc];
  // CPU is held in reset throughout LOAD, including the HALT cycle that leaves for LOAD
  assign cpu_go    = (state == S_RUN) || ((state == S_HALT) && !load_valid);

  assign is_c     = instr[15];
  assign dmem_hit = (a_reg >> DMEM_AW) == '0;
  assign io_hit   = !dmem_hit && (a_reg == IO_ADDR);
  assign in_m     = dmem_hit ? dmem[a_reg[DMEM_AW-1:0]] : (io_hit ? io_in : '0);
  assign y_op     = instr[12] ? in_m : a_reg;

  always_comb begin
    x_v = instr[11] ? '0 : d_reg;
    if (instr[10]) x_v = ~x_v;
    y_v = instr[9] ? '0 : y_op;
    if (instr[8]) y_v = ~y_v;
    alu = instr[7] ? (x_v + y_v) : (x_v & y_v);
    if (instr[6]) alu = ~alu;
  end

  assign zr        = (alu == '0);
  assign ng        = alu[15];
  assign take_jump = is_c && ((instr[2] && ng) || (instr[1] && zr) || (instr[0] && !ng && !zr));
  assign write_m   = cpu_go && is_c && instr[3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg <= '0;
      d_reg <= '0;
      pc    <= '0;
    end else if (!cpu_go) begin
      a_reg <= '0;
      d_reg <= '0;
      pc    <= '0;
    end else begin
      if (!is_c)
        a_reg <= instr;
      else if (instr[5])
        a_reg <= alu;
      if (is_c && instr[4])
        d_reg <= alu;
      pc <= take_jump ? a_reg[IMEM_AW-1:0] : pc + IMEM_AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire)
      imem[load_ptr] <= load_data;
    if (write_m && dmem_hit)
      dmem[a_reg[DMEM_AW-1:0]] <= alu;
  end

  assign halt_hit = prev_at && (pc == prev_pc + IMEM_AW'(1)) &&
                    (instr[15:13] == 3'b111) && (instr[5:0] == 6'b000111);

`ifdef MY_COMPUTER_SYS_WDOG_EN
  assign wdog_hit = (cycles == CYC_W'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_LOAD;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    running    = 1'b0;
    halted     = 1'b0;
    unique case (state)
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid && (load_last || (&load_ptr)))
          state_next = S_RUN;
      end
      S_RUN: begin
        running = 1'b1;
        if (halt_hit || wdog_hit)
          state_next = S_HALT;
      end
      S_HALT: begin
        halted = 1'b1;
        if (load_valid)
          state_next = S_LOAD;
      end
      default: state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_ptr     <= '0;
      cycles       <= '0;
      io_out       <= '0;
      io_out_valid <= 1'b0;
      prev_pc      <= '0;
      prev_at      <= 1'b0;
    end else begin
      io_out_valid <= write_m && io_hit;
      if (write_m && io_hit)
        io_out <= alu;
      if (state != S_LOAD)
        load_ptr <= '0;
      else if (load_fire)
        load_ptr <= load_ptr + IMEM_AW'(1);
      if (state == S_LOAD)
        cycles <= '0;
      else if ((state == S_RUN) && !(&cycles))
        cycles <= cycles + CYC_W'(1);
      prev_pc <= pc;
      prev_at <= (state == S_RUN) && !instr[15] && (instr[14:0] == 15'(pc));
    end
  end

`ifdef MY_COMPUTER_SYS_WDOG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wdog_fired <= 1'b0;
    else if (state == S_LOAD)
      wdog_fired <= 1'b0;
    else if ((state == S_RUN) && wdog_hit)
      wdog_fired <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_my_computer_sys.sv
`timescale 1ns/1ps
module tb_my_computer_sys;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_last = 1'b0;
  logic [15:0] load_data = '0;
  logic [15:0] io_in = '0;
  logic        load_ready, io_out_valid, running, halted;
  logic [15:0] io_out;
  logic [31:0] cycles;
  logic [14:0] pc;
`ifdef MY_COMPUTER_SYS_WDOG_EN
  logic        wdog_fired;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_on  = 1'b0;

  always #5 clk = ~clk;

  my_computer_sys #(.WDOG_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .io_in(io_in), .io_out(io_out),
    .io_out_valid(io_out_valid), .running(running), .halted(halted),
    .cycles(cycles), .pc(pc)
`ifdef MY_COMPUTER_SYS_WDOG_EN
    , .wdog_fired(wdog_fired)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef enum {M_LOAD, M_RUN, M_HALT} mode_t;
  mode_t       m_mode = M_LOAD;
  logic [15:0] m_imem [int];
  logic [15:0] m_dmem [int];
  int unsigned m_ptr = 0;
  logic [14:0] m_pc = '0, m_prev_pc = '0;
  logic [15:0] m_a = '0, m_d = '0, m_io = '0;
  logic        m_io_v = 1'b0, m_prev_at = 1'b0, m_wdog = 1'b0;
  logic [31:0] m_cyc = '0;

  function automatic logic [15:0] comp_val(input logic [5:0] c, input logic [15:0] d, input logic [15:0] y);
    case (c)
      6'b101010: return 16'd0;
      6'b111111: return 16'd1;
      6'b111010: return 16'hFFFF;
      6'b001100: return d;
      6'b110000: return y;
      6'b001101: return ~d;
      6'b110001: return ~y;
      6'b001111: return -d;
      6'b110011: return -y;
      6'b011111: return d + 16'd1;
      6'b110111: return y + 16'd1;
      6'b001110: return d - 16'd1;
      6'b110010: return y - 16'd1;
      6'b000010: return d + y;
      6'b010011: return d - y;
      6'b000111: return y - d;
      6'b000000: return d & y;
      6'b010101: return d | y;
      default:   return 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] mem_rd(input logic [15:0] addr);
    if (addr < 16'h4000) return m_dmem.exists(int'(addr)) ? m_dmem[int'(addr)] : 16'h0;
    if (addr == 16'h6000) return io_in;
    return 16'h0;
  endfunction

  function automatic logic [15:0] imem_rd(input logic [14:0] a);
    return m_imem.exists(int'(a)) ? m_imem[int'(a)] : 16'h0;
  endfunction

  task automatic exec_one();
    logic [15:0] i, r;
    logic [14:0] npc;
    bit          jmp;
    i = imem_rd(m_pc);
    npc = m_pc + 15'd1;
    if (!i[15]) begin
      m_a = i;
    end else begin
      r = comp_val(i[11:6], m_d, i[12] ? mem_rd(m_a) : m_a);
      jmp = (i[2] && $signed(r) < 0) || (i[1] && r == 16'd0) || (i[0] && $signed(r) > 0);
      if (jmp) npc = m_a[14:0];
      if (i[3]) begin
        if (m_a < 16'h4000) m_dmem[int'(m_a)] = r;
        else if (m_a == 16'h6000) begin m_io = r; m_io_v = 1'b1; end
      end
      if (i[5]) m_a = r;
      if (i[4]) m_d = r;
    end
    m_pc = npc;
  endtask

  task automatic model_step();
    logic [15:0] cur;
    bit          hit;
    m_io_v = 1'b0;
    case (m_mode)
      M_LOAD: begin
        m_cyc = '0; m_wdog = 1'b0; m_prev_at = 1'b0;
        if (load_valid) begin
          m_imem[int'(m_ptr)] = load_data;
          if (load_last || m_ptr == 32767) m_mode = M_RUN;
          m_ptr++;
        end
      end
      M_RUN: begin
        cur = imem_rd(m_pc);
        hit = m_prev_at && (m_pc == m_prev_pc + 15'd1) && cur[15:13] == 3'b111 && cur[5:0] == 6'b000111;
        m_prev_at = !cur[15] && (cur[14:0] == m_pc);
        m_prev_pc = m_pc;
        exec_one();
        if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
        if (hit) m_mode = M_HALT;
`ifdef MY_COMPUTER_SYS_WDOG_EN
        if (m_cyc == 32'd50) begin m_mode = M_HALT; m_wdog = 1'b1; end
`endif
      end
      default: begin
        m_prev_at = 1'b0;
        if (load_valid) begin
          m_mode = M_LOAD; m_ptr = 0; m_pc = '0; m_a = '0; m_d = '0;
        end else begin
          exec_one();
        end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_mode = M_LOAD; m_ptr = 0; m_cyc = '0; m_io = '0; m_io_v = 1'b0;
      m_pc = '0; m_a = '0; m_d = '0; m_prev_at = 1'b0; m_wdog = 1'b0;
    end else begin
      model_step();
    end
  end

  int          pulses = 0;
  int          ready_in_run = 0;
  logic [15:0] io_seen[$];

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      check("ready",    load_ready,   m_mode == M_LOAD);
      check("running",  running,      m_mode == M_RUN);
      check("halted",   halted,       m_mode == M_HALT);
      check("pc",       pc,           m_pc);
      check("cycles",   cycles,       m_cyc);
      check("io_out",   io_out,       m_io);
      check("io_valid", io_out_valid, m_io_v);
`ifdef MY_COMPUTER_SYS_WDOG_EN
      check("wdog",     wdog_fired,   m_wdog);
`endif
      if (io_out_valid) begin pulses++; io_seen.push_back(io_out); end
      if (running && load_ready) ready_in_run++;
    end
  end

  logic [15:0] prog[$];

  task automatic clear_mon();
    pulses = 0; ready_in_run = 0; io_seen.delete();
  endtask

  task automatic load_prog(input bit rnd);
    int unsigned idx = 0;
    int unsigned guard = 0;
    bit acc;
    @(posedge clk); #2;
    while (idx < prog.size() && guard < 5000) begin
      load_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      load_data  = prog[idx];
      load_last  = (idx == prog.size() - 1);
      acc = load_valid && load_ready;
      @(posedge clk); #2;
      if (acc) idx++;
      guard++;
    end
    load_valid = 1'b0; load_last = 1'b0;
    n_tests++;
    if (idx != prog.size()) begin
      n_fail++;
      $display("FAIL load_timeout: accepted %0d words, required %0d", idx, prog.size());
    end
  endtask

  task automatic wait_halt(input string name, input int unsigned lim);
    int unsigned k = 0;
    while (!halted && k < lim) begin @(negedge clk); k++; end
    check(name, halted, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    cmp_on = 1'b1;
    @(negedge clk);
    check("rst_ready", load_ready, 1'b1);
    check("rst_run",   running, 1'b0);
    check("rst_halt",  halted, 1'b0);
    check("rst_cyc",   cycles, 32'd0);
    check("rst_io",    io_out, 16'h0000);
    check("rst_pc",    pc, 15'd0);

    prog = '{16'h0007, 16'hEC10, 16'h6000, 16'hE308, 16'h0004, 16'hEA87};
    clear_mon();
    load_prog(1'b0);
    wait_halt("t1_halt", 200);
    check("t1_io", io_out, 16'h0007);
    check("t1_pulses", pulses, 1);
    check("t1_cyc", cycles, 32'd6);
    repeat (20) @(negedge clk);
    check("t1_cyc_frozen", cycles, 32'd6);

    clear_mon();
    load_prog(1'b1);
    wait_halt("t2_halt", 200);
    check("t2_io", io_out, 16'h0007);
    check("t2_pulses", pulses, 1);
    check("t2_cyc", cycles, 32'd6);
    check("t2_ready_in_run", ready_in_run, 0);

    io_in = 16'h1234;
    prog = '{16'h6000, 16'hFC10, 16'h6000, 16'hE7C8, 16'h0004, 16'hEA87};
    clear_mon();
    load_prog(1'b0);
    wait_halt("t3_halt", 200);
    check("t3_io", io_out, 16'h1235);
    check("t3_pulses", pulses, 1);

    prog = '{16'h0055, 16'hEC10, 16'h0000, 16'hE308, 16'h7000, 16'hE308, 16'hFC10,
             16'h6000, 16'hE308, 16'h0000, 16'hFC10, 16'h6000, 16'hE308, 16'h000D, 16'hEA87};
    clear_mon();
    load_prog(1'b0);
    wait_halt("t4_halt", 300);
    check("t4_pulses", pulses, 2);
    check("t4_unmapped_rd", io_seen.size() > 0 ? io_seen[0] : 16'hDEAD, 16'h0000);
    check("t4_ram0", io_seen.size() > 1 ? io_seen[1] : 16'hDEAD, 16'h0055);
    check("t4_cyc", cycles, 32'd15);

    prog = '{16'h0007, 16'hEC10, 16'h6000, 16'hE308, 16'h0004, 16'hEA87};
    load_prog(1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    check("t5_pc", pc, 15'd0);
    check("t5_cyc", cycles, 32'd0);
    check("t5_io", io_out, 16'h0000);
    check("t5_ready", load_ready, 1'b1);
    @(posedge clk); #2;
    reset = 1'b1;
    prog = '{16'h002A, 16'hEC10, 16'h6000, 16'hE308, 16'h0004, 16'hEA87};
    clear_mon();
    load_prog(1'b0);
    wait_halt("t5_halt", 200);
    check("t5_io_new", io_out, 16'h002A);
    check("t5_pulses", pulses, 1);
    check("t5_cyc_new", cycles, 32'd6);

`ifdef MY_COMPUTER_SYS_WDOG_EN
    prog = '{16'h0000, 16'hEC10, 16'h0000, 16'hEA87};
    load_prog(1'b0);
    wait_halt("t6_halt", 300);
    check("t6_wdog", wdog_fired, 1'b1);
    check("t6_cyc", cycles, 32'd50);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
